// File: rtl/prbs_word_gen.sv
// PRBS-15 (x^15+x^14+1) pattern source that packs 16 LFSR steps per word and
// offers the words over a valid/ready handshake, with single-bit error injection.
module prbs_word_gen #(
  parameter logic [14:0] SEED      = 15'h7FFF,
  parameter int unsigned NUM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        inject_err,
  input  logic        ready_in,
  output logic [15:0] data_out,
  output logic        valid_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] word_count,
  output logic [15:0] injected_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] LAST_COUNT = 32'(NUM_WORDS);

  // Returns {word, lfsr advanced 16 steps}; the first generated bit lands in word[15].
  function automatic logic [30:0] prbs_step16(input logic [14:0] s_in);
    logic [14:0] s;
    logic [15:0] w;
    logic        nb;
    s = s_in;
    w = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      nb = s[14] ^ s[13];
      w  = {w[14:0], nb};
      s  = {s[13:0], nb};
    end
    return {w, s};
  endfunction

  state_t      state_q, state_d;
  logic [14:0] lfsr_q, lfsr_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [15:0] inj_cnt_q, inj_cnt_d;
  logic        err_pend_q, err_pend_d;
  // cur_err_q marks that the word currently on data_out carries an injected flip
  logic        cur_err_q, cur_err_d;

  logic [30:0] seed_step_s;
  logic [30:0] run_step_s;
  logic        xfer_s;
  logic [31:0] cnt_inc_s;

  assign seed_step_s = prbs_step16(SEED);
  assign run_step_s  = prbs_step16(lfsr_q);
  assign xfer_s      = valid_q & ready_in;
  assign cnt_inc_s   = word_cnt_q + 32'd1;

  // Next-state logic for the run controller, word generator and counters.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    word_cnt_d = word_cnt_q;
    inj_cnt_d  = inj_cnt_q;
    err_pend_d = err_pend_q;
    cur_err_d  = cur_err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          data_d     = seed_step_s[30:15];
          lfsr_d     = seed_step_s[14:0];
          valid_d    = 1'b1;
          word_cnt_d = 32'd0;
          inj_cnt_d  = 16'd0;
          err_pend_d = inject_err;
          cur_err_d  = 1'b0;
        end else begin
          valid_d    = 1'b0;
          err_pend_d = 1'b0;
          cur_err_d  = 1'b0;
        end
      end

      ST_RUN: begin
        if (xfer_s) begin
          word_cnt_d = cnt_inc_s;
          if (cur_err_q && (inj_cnt_q != 16'hFFFF)) begin
            inj_cnt_d = inj_cnt_q + 16'd1;
          end else begin
            inj_cnt_d = inj_cnt_q;
          end
        end else begin
          word_cnt_d = word_cnt_q;
          inj_cnt_d  = inj_cnt_q;
        end

        // Abort outranks run completion so an aborted run never reports done.
        if (abort) begin
          state_d    = ST_IDLE;
          valid_d    = 1'b0;
          err_pend_d = 1'b0;
          cur_err_d  = 1'b0;
        end else if (xfer_s && (cnt_inc_s == LAST_COUNT)) begin
          state_d    = ST_DONE;
          valid_d    = 1'b0;
          err_pend_d = 1'b0;
          cur_err_d  = 1'b0;
        end else if (xfer_s) begin
          data_d     = run_step_s[30:15] ^ {15'd0, err_pend_q};
          lfsr_d     = run_step_s[14:0];
          cur_err_d  = err_pend_q;
          err_pend_d = inject_err;
        end else begin
          err_pend_d = err_pend_q | inject_err;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        valid_d    = 1'b0;
        err_pend_d = 1'b0;
        cur_err_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      data_q     <= 16'h0000;
      valid_q    <= 1'b0;
      word_cnt_q <= 32'd0;
      inj_cnt_q  <= 16'd0;
      err_pend_q <= 1'b0;
      cur_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      word_cnt_q <= word_cnt_d;
      inj_cnt_q  <= inj_cnt_d;
      err_pend_q <= err_pend_d;
      cur_err_q  <= cur_err_d;
    end
  end

  assign data_out       = data_q;
  assign valid_out      = valid_q;
  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign word_count     = word_cnt_q;
  assign injected_count = inj_cnt_q;

endmodule

// File: tb/tb_prbs_word_gen.sv
// Directed bench for prbs_word_gen: reset, free-running sequence, short run,
// backpressure, error injection, abort and mid-run reset.
module tb_prbs_word_gen;

  logic        clk = 1'b0;
  logic        reset, start, abort, inject_err, ready_in;
  logic [15:0] data_out;
  logic        valid_out, busy, done;
  logic [31:0] word_count;
  logic [15:0] injected_count;

  logic        start4, ready4, tie_lo;
  logic [15:0] data4;
  logic        valid4, busy4, done4;
  logic [31:0] wc4;
  logic [15:0] ic4;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [14:0] ref_lfsr;
  logic [15:0] exp_w, prev_data;
  logic        prev_valid, prev_rdy;
  int          n_xfer;
  logic [15:0] hand_words [0:4] = '{16'h0002, 16'h000C, 16'h0028, 16'h00F0, 16'h0220};

  always #5 clk = ~clk;

  prbs_word_gen #(.SEED(15'h7FFF), .NUM_WORDS(40)) u_dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .inject_err(inject_err),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out), .busy(busy),
    .done(done), .word_count(word_count), .injected_count(injected_count)
  );

  prbs_word_gen #(.SEED(15'h7FFF), .NUM_WORDS(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(tie_lo), .inject_err(tie_lo),
    .ready_in(ready4), .data_out(data4), .valid_out(valid4), .busy(busy4),
    .done(done4), .word_count(wc4), .injected_count(ic4)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Serial reference: one PRBS-15 bit per step, first bit is the word MSB.
  task automatic ref_next(output logic [15:0] w);
    logic nb;
    w = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      nb       = ref_lfsr[14] ^ ref_lfsr[13];
      w        = {w[14:0], nb};
      ref_lfsr = {ref_lfsr[13:0], nb};
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; inject_err = 1'b0; ready_in = 1'b0;
    start4 = 1'b0; ready4 = 1'b0; tie_lo = 1'b0;
    tick; tick;
    check_eq("rst_data", data_out, 32'h0);
    check_eq("rst_valid", valid_out, 32'h0);
    check_eq("rst_busy", busy, 32'h0);
    check_eq("rst_done", done, 32'h0);
    check_eq("rst_wc", word_count, 32'h0);
    check_eq("rst_ic", injected_count, 32'h0);
    reset = 1'b1;
    tick;
    check_eq("idle_valid", valid_out, 32'h0);

    // Free-running sequence with ready held high
    ready_in = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    check_eq("first_valid", valid_out, 32'h1);
    check_eq("first_busy", busy, 32'h1);
    check_eq("first_wc", word_count, 32'h0);
    check_eq("first_word", data_out, 32'h0002);
    ref_lfsr = 15'h7FFF;
    ref_next(exp_w);
    check_eq("model_word0", data_out, {16'h0, exp_w});
    for (int k = 1; k < 40; k++) begin
      tick;
      ref_next(exp_w);
      check_eq("run_data", data_out, {16'h0, exp_w});
      check_eq("run_wc", word_count, k);
      if (k < 5) check_eq("hand_word", data_out, {16'h0, hand_words[k]});
    end
    tick;
    check_eq("end_wc", word_count, 32'd40);
    check_eq("end_valid", valid_out, 32'h0);
    check_eq("end_done", done, 32'h1);
    check_eq("end_busy", busy, 32'h0);

    // Four-word run
    ready4 = 1'b1; start4 = 1'b1;
    tick;
    start4 = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    check_eq("n4_done_early", done4, 32'h0);
    check_eq("n4_valid_early", valid4, 32'h1);
    check_eq("n4_wc3", wc4, 32'd3);
    tick;
    check_eq("n4_wc", wc4, 32'd4);
    check_eq("n4_done", done4, 32'h1);
    check_eq("n4_valid", valid4, 32'h0);
    tick; tick;
    check_eq("n4_wc_hold", wc4, 32'd4);

    // Random backpressure, restarting from DONE
    ready_in = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    ref_lfsr = 15'h7FFF;
    ref_next(exp_w);
    n_xfer = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      ready_in   = 1'($urandom_range(0, 1));
      prev_data  = data_out;
      prev_valid = valid_out;
      prev_rdy   = ready_in;
      tick;
      if (prev_valid && prev_rdy) begin
        check_eq("bp_word", {16'h0, prev_data}, {16'h0, exp_w});
        ref_next(exp_w);
        n_xfer++;
      end else if (prev_valid && valid_out) begin
        check_eq("bp_stable", data_out, {16'h0, prev_data});
      end
    end
    check_eq("bp_done", done, 32'h1);
    check_eq("bp_wc", word_count, 32'd40);
    check_eq("bp_xfers", n_xfer, 32'd40);

    // Error injection: two merged pulses, then one more
    ready_in = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    check_eq("inj_w0", data_out, 32'h0002);
    inject_err = 1'b1;
    tick; tick;
    inject_err = 1'b0;
    check_eq("inj_w0_held", data_out, 32'h0002);
    check_eq("inj_ic0", injected_count, 32'h0);
    ready_in = 1'b1;
    tick;
    check_eq("inj_w1", data_out, 32'h000D);
    check_eq("inj_ic_a", injected_count, 32'h0);
    tick;
    check_eq("inj_w2", data_out, 32'h0028);
    check_eq("inj_ic_b", injected_count, 32'h1);
    ready_in = 1'b0; inject_err = 1'b1;
    tick;
    inject_err = 1'b0;
    check_eq("inj_w2_held", data_out, 32'h0028);
    ready_in = 1'b1;
    tick;
    check_eq("inj_w3", data_out, 32'h00F1);
    check_eq("inj_ic_c", injected_count, 32'h1);
    tick;
    check_eq("inj_w4", data_out, 32'h0220);
    check_eq("inj_ic_d", injected_count, 32'h2);
    check_eq("inj_wc", word_count, 32'd4);
    for (int c = 0; c < 100 && !done; c++) tick;
    check_eq("inj_done", done, 32'h1);
    check_eq("inj_ic_end", injected_count, 32'h2);
    check_eq("inj_wc_end", word_count, 32'd40);

    // Abort with a transfer in the abort cycle
    ready_in = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    check_eq("ab_wc3", word_count, 32'd3);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check_eq("ab_wc", word_count, 32'd4);
    check_eq("ab_busy", busy, 32'h0);
    check_eq("ab_done", done, 32'h0);
    check_eq("ab_valid", valid_out, 32'h0);
    tick; tick;
    check_eq("ab_wc_hold", word_count, 32'd4);
    check_eq("ab_valid_hold", valid_out, 32'h0);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    check_eq("ab_idle_ignore", busy, 32'h0);
    start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    check_eq("rs_busy", busy, 32'h1);
    check_eq("rs_word", data_out, 32'h0002);
    check_eq("rs_wc", word_count, 32'h0);
    check_eq("rs_ic", injected_count, 32'h0);

    // Asynchronous reset in the middle of a run
    tick; tick;
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_data", data_out, 32'h0);
    check_eq("ar_valid", valid_out, 32'h0);
    check_eq("ar_busy", busy, 32'h0);
    check_eq("ar_wc", word_count, 32'h0);
    tick; tick;
    reset = 1'b1;
    tick; tick; tick;
    check_eq("ar_post_valid", valid_out, 32'h0);
    check_eq("ar_post_busy", busy, 32'h0);
    check_eq("ar_post_done", done, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
